// File: rtl/window_line_buffer.sv
// Streaming KxK sliding-window generator.
// Takes a raster-order stream with CHANNELS samples per beat and keeps K-1
// line memories plus a KxK window register. It emits one packed window per
// valid output position, with STRIDE applied in both x and y. One output
// register sits behind a ready/valid handshake on each side.
module window_line_buffer #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 32,
  parameter int IMAGE_HEIGHT = 32,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int CHANNELS     = 1
) (
  input  logic                                                      clk,
  input  logic                                                      reset_wire,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                            s_data,
  input  logic                                                      s_valid,
  output logic                                                      s_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0]    m_data,
  output logic                                                      m_valid,
  input  logic                                                      m_ready,
  output logic                                                      m_last,
  output logic                                                      frame_done
);

  localparam int K   = KERNEL_SIZE;
  localparam int PW  = CHANNELS * DATA_WIDTH;
  localparam int WW  = K * K * PW;
  localparam int CW  = $clog2(IMAGE_WIDTH) + 1;
  localparam int RW  = $clog2(IMAGE_HEIGHT) + 1;
  localparam int AW  = $clog2(IMAGE_WIDTH);
  localparam int PHW = $clog2(STRIDE) + 1;

  localparam logic [CW-1:0]  COL_MAX   = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_MAX   = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0]  COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0]  ROW_FIRST = RW'(K - 1);
  localparam logic [CW-1:0]  COL_LASTW = CW'(IMAGE_WIDTH - 1 - ((IMAGE_WIDTH - K) % STRIDE));
  localparam logic [RW-1:0]  ROW_LASTW = RW'(IMAGE_HEIGHT - 1 - ((IMAGE_HEIGHT - K) % STRIDE));
  localparam logic [CW-1:0]  COL_ONE   = CW'(1);
  localparam logic [RW-1:0]  ROW_ONE   = RW'(1);
  localparam logic [PHW-1:0] PH_MAX    = PHW'(STRIDE - 1);
  localparam logic [PHW-1:0] PH_ONE    = PHW'(1);
  localparam logic [PHW-1:0] PH_ZERO   = {PHW{1'b0}};

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PHW-1:0] col_ph_q, col_ph_d;
  logic [PHW-1:0] row_ph_q, row_ph_d;
  logic [WW-1:0]  win_q, win_d;
  logic [WW-1:0]  m_data_q, m_data_d;
  logic           m_valid_q, m_valid_d;
  logic           m_last_q, m_last_d;
  logic           frame_done_q, frame_done_d;

  logic [PW-1:0]  line_mem_q [K-1][IMAGE_WIDTH];
  logic [PW-1:0]  new_col_s [K];
  logic [WW-1:0]  win_shift_s;
  logic [AW-1:0]  col_idx_s;
  logic           accept_s, col_end_s, row_end_s, emit_s, last_s;

  // The single output stage frees up whenever it is empty or being drained.
  assign s_ready   = ~m_valid_q | m_ready;
  assign accept_s  = s_valid & s_ready;
  assign col_idx_s = col_q[AW-1:0];
  assign col_end_s = (col_q == COL_MAX);
  assign row_end_s = (row_q == ROW_MAX);

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;

  // Build the incoming window column (oldest row first) and the window shifted left by one column.
  always_comb begin
    for (int kr = 0; kr < K - 1; kr++) begin
      new_col_s[kr] = line_mem_q[kr][col_idx_s];
    end
    new_col_s[K-1] = s_data;
    win_shift_s = win_q;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K - 1; kc++) begin
        win_shift_s[(kr*K + kc)*PW +: PW] = win_q[(kr*K + kc + 1)*PW +: PW];
      end
      win_shift_s[(kr*K + K - 1)*PW +: PW] = new_col_s[kr];
    end
  end

  // Emit only once K rows and K columns are available and both stride phases are aligned.
  always_comb begin
    emit_s = accept_s & (row_q >= ROW_FIRST) & (col_q >= COL_FIRST) &
             (row_ph_q == PH_ZERO) & (col_ph_q == PH_ZERO);
    last_s = (row_q == ROW_LASTW) & (col_q == COL_LASTW);
  end

  // Raster position and stride phase bookkeeping; everything wraps at the end of the frame.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    if (accept_s) begin
      if (col_end_s) begin
        col_d    = {CW{1'b0}};
        col_ph_d = PH_ZERO;
        if (row_end_s) begin
          row_d    = {RW{1'b0}};
          row_ph_d = PH_ZERO;
        end else begin
          row_d = row_q + ROW_ONE;
          if (row_q >= ROW_FIRST) begin
            row_ph_d = (row_ph_q == PH_MAX) ? PH_ZERO : row_ph_q + PH_ONE;
          end else begin
            row_ph_d = PH_ZERO;
          end
        end
      end else begin
        col_d = col_q + COL_ONE;
        if (col_q >= COL_FIRST) begin
          col_ph_d = (col_ph_q == PH_MAX) ? PH_ZERO : col_ph_q + PH_ONE;
        end else begin
          col_ph_d = PH_ZERO;
        end
      end
    end else begin
      col_d = col_q;
    end
  end

  // Window register, output stage and end-of-frame pulse.
  always_comb begin
    win_d        = accept_s ? win_shift_s : win_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    frame_done_d = accept_s & col_end_s & row_end_s;
    if (emit_s) begin
      m_valid_d = 1'b1;
      m_data_d  = win_shift_s;
      m_last_d  = last_s;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset_wire) begin
    if (!reset_wire) begin
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      col_ph_q     <= PH_ZERO;
      row_ph_q     <= PH_ZERO;
      win_q        <= {WW{1'b0}};
      m_data_q     <= {WW{1'b0}};
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      col_ph_q     <= col_ph_d;
      row_ph_q     <= row_ph_d;
      win_q        <= win_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line memories act as a per-column shift chain; the row counter keeps stale contents from being used.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int i = 0; i < K - 2; i++) begin
        line_mem_q[i][col_idx_s] <= line_mem_q[i+1][col_idx_s];
      end
      line_mem_q[K-2][col_idx_s] <= s_data;
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer: three configurations (K=3, 5x5 image)
// S=1/C=1, S=2/C=1 and S=1/C=2, each with its own driver, reference model and monitor.
module tb_window_line_buffer;
  localparam int K = 3, W = 5, H = 5, DW = 16, NCFG = 3;
  localparam int MAXW = K*K*2*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_wire;

  int total = 0, bad = 0, cyc = 0;
  int vp = 100, rp = 100, req = 0, batch = 0;
  bit rand_pix = 1'b0, stall_mode = 1'b0;
  int pl_a[NCFG], win_a[NCFG], last_a[NCFG], fd_a[NCFG], ql_a[NCFG];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int S  = (g == 1) ? 2 : 1;
    localparam int C  = (g == 2) ? 2 : 1;
    localparam int PW = C*DW;
    localparam int MW = K*K*PW;

    logic [PW-1:0] s_data;
    logic [MW-1:0] m_data;
    logic s_valid, s_ready, m_valid, m_ready, m_last, frame_done;

    window_line_buffer #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
                         .KERNEL_SIZE(K), .STRIDE(S), .CHANNELS(C)) dut (
      .clk(clk), .reset_wire(reset_wire), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .frame_done(frame_done));

    int pix_left = 0, pidx = 0, my_batch = 0, stall_left = 0;
    int mr = 0, mc = 0, win_cnt = 0, last_cnt = 0, fd_cnt = 0, qlen = 0;
    bit acc_seen = 1'b0, need_new = 1'b1, held = 1'b0, fd_expect = 1'b0, first_pending = 1'b1;
    bit held_l, el;
    int ec;
    logic [MW-1:0] held_d, ed;
    logic [PW-1:0] img [H][W];
    logic [MW-1:0] exp_d_q[$];
    bit exp_l_q[$];
    int exp_c_q[$];
    logic [MAXW-1:0] md;
    bit ok;

    assign pl_a[g] = pix_left;
    assign win_a[g] = win_cnt;
    assign last_a[g] = last_cnt;
    assign fd_a[g] = fd_cnt;
    assign ql_a[g] = qlen;

    // Pixel source and downstream ready generator.
    initial begin
      s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      forever begin
        @(posedge clk); #1;
        if (acc_seen) begin pidx = (pidx + 1) % (W*H); pix_left--; need_new = 1'b1; end
        if (!reset_wire) begin pidx = 0; need_new = 1'b1; end
        if (batch != my_batch) begin
          my_batch = batch; pix_left = req; stall_left = stall_mode ? 10 : 0;
        end
        if (need_new) begin
          for (int ch = 0; ch < C; ch++)
            s_data[ch*DW +: DW] = rand_pix ? DW'($urandom) : DW'(ch*100 + pidx);
          need_new = 1'b0;
        end
        s_valid = (pix_left > 0) && reset_wire && ($urandom_range(99) < vp);
        m_ready = ($urandom_range(99) < rp);
        if (stall_left > 0 && m_valid) begin m_ready = 1'b0; stall_left--; end
      end
    end

    // Reference model and output monitor.
    always @(negedge clk) begin
      if (!reset_wire) begin
        total++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || frame_done !== 1'b0 || m_data !== '0) begin
          bad++;
          $display("FAIL reset_outputs cfg%0d: m_valid=%0b m_last=%0b frame_done=%0b m_data=%h, required all zero",
                   g, m_valid, m_last, frame_done, m_data);
        end
        mr = 0; mc = 0; held = 1'b0; fd_expect = 1'b0; acc_seen = 1'b0; first_pending = 1'b1;
        exp_d_q.delete(); exp_l_q.delete(); exp_c_q.delete(); qlen = 0;
      end else begin
        total++;
        if (s_ready !== (!m_valid || m_ready)) begin
          bad++;
          $display("FAIL s_ready cfg%0d: got %0b, required %0b (m_valid=%0b m_ready=%0b)",
                   g, s_ready, !m_valid || m_ready, m_valid, m_ready);
        end
        if (m_valid) begin
          if (held) begin
            total++;
            if (m_data !== held_d || m_last !== held_l) begin
              bad++;
              $display("FAIL hold_stable cfg%0d: data=%h last=%0b, required data=%h last=%0b",
                       g, m_data, m_last, held_d, held_l);
            end
          end else begin
            win_cnt++;
            if (m_last) last_cnt++;
            total++;
            if (exp_d_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_window cfg%0d: got data=%h, required no window", g, m_data);
            end else begin
              ed = exp_d_q.pop_front(); el = exp_l_q.pop_front(); ec = exp_c_q.pop_front();
              qlen = exp_d_q.size();
              if (m_data !== ed || m_last !== el || cyc != ec + 1) begin
                bad++;
                $display("FAIL window cfg%0d: got data=%h last=%0b cycle=%0d, required data=%h last=%0b cycle=%0d",
                         g, m_data, m_last, cyc, ed, el, ec + 1);
              end
            end
            if (first_pending) begin
              md = '0; md[MW-1:0] = m_data; ok = 1'b1;
              for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++)
                  for (int ch = 0; ch < C; ch++)
                    if (md[((kr*K + kc)*C + ch)*DW +: DW] !== DW'(ch*100 + kr*W + kc)) ok = 1'b0;
              total++;
              if (!ok || m_last !== 1'b0) begin
                bad++;
                $display("FAIL first_window cfg%0d: got data=%h last=%0b, required r*5+c (+100 for ch1) packing, last=0",
                         g, m_data, m_last);
              end
              first_pending = 1'b0;
            end
          end
          held = !m_ready; held_d = m_data; held_l = m_last;
        end else begin
          if (held) begin
            total++; bad++;
            $display("FAIL valid_dropped cfg%0d: got m_valid=0 while stalled, required 1", g);
          end
          held = 1'b0;
        end
        if (frame_done || fd_expect) begin
          total++;
          if (frame_done !== fd_expect) begin
            bad++;
            $display("FAIL frame_done cfg%0d: got %0b, required %0b", g, frame_done, fd_expect);
          end
        end
        if (frame_done) fd_cnt++;
        fd_expect = 1'b0;
        acc_seen = s_valid && s_ready;
        if (acc_seen) begin
          img[mr][mc] = s_data;
          if (mr >= K-1 && mc >= K-1 && (mr-K+1) % S == 0 && (mc-K+1) % S == 0) begin
            ed = '0;
            for (int kr = 0; kr < K; kr++)
              for (int kc = 0; kc < K; kc++)
                ed[(kr*K + kc)*PW +: PW] = img[mr-K+1+kr][mc-K+1+kc];
            exp_d_q.push_back(ed);
            exp_l_q.push_back(mr == H-1-((H-K) % S) && mc == W-1-((W-K) % S));
            exp_c_q.push_back(cyc);
            qlen = exp_d_q.size();
          end
          if (mr == H-1 && mc == W-1) fd_expect = 1'b1;
          mc++;
          if (mc == W) begin mc = 0; mr++; if (mr == H) mr = 0; end
        end
      end
    end
  end

  int strides[NCFG] = '{1, 2, 1};

  task automatic run_batch(input string name, input int npix, input int frames);
    int bw[NCFG], bl[NCFG], bf[NCFG];
    int wpf;
    bit done;
    for (int i = 0; i < NCFG; i++) begin bw[i] = win_a[i]; bl[i] = last_a[i]; bf[i] = fd_a[i]; end
    req = npix;
    batch++;
    repeat (2) @(posedge clk);
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(posedge clk);
      done = 1'b1;
      for (int i = 0; i < NCFG; i++) if (pl_a[i] != 0 || ql_a[i] != 0) done = 1'b0;
    end
    repeat (4) @(posedge clk);
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: stream not drained within 3000 cycles, required drained", name);
    end
    for (int i = 0; i < NCFG; i++) begin
      wpf = ((W-K)/strides[i] + 1) * ((H-K)/strides[i] + 1);
      total++;
      if (win_a[i]-bw[i] != frames*wpf || last_a[i]-bl[i] != frames || fd_a[i]-bf[i] != frames) begin
        bad++;
        $display("FAIL %s_counts cfg%0d: got windows=%0d last=%0d frame_done=%0d, required %0d/%0d/%0d",
                 name, i, win_a[i]-bw[i], last_a[i]-bl[i], fd_a[i]-bf[i], frames*wpf, frames, frames);
      end
    end
  endtask

  initial begin
    reset_wire = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_wire = 1'b1;

    vp = 100; rp = 100; rand_pix = 1'b0; stall_mode = 1'b0;
    run_batch("full_frame", W*H, 1);

    stall_mode = 1'b1;
    run_batch("stall_frame", W*H, 1);
    stall_mode = 1'b0;

    run_batch("partial", 7, 0);
    @(posedge clk); #2 reset_wire = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_wire = 1'b1;
    run_batch("after_reset", W*H, 1);

    vp = 50; rp = 50; rand_pix = 1'b1;
    run_batch("random_two_frames", 2*W*H, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
